// File: rtl/alu_op_issue.sv
// ---------------------------------------------------------------------------
// alu_op_issue
//
// Front-end producer for the ALU opcode space (kADD..kSLT, 4'h0..4'h9).
// Accepts instruction words over a valid/ready handshake and decodes the top
// four bits into an ALU op. It tags the op with its operand field and class
// flags. It issues the op downstream through a registered output stage that
// is backed by a one-entry skid buffer. An illegal opcode (4'hA..4'hF) halts
// the issuer with a sticky error that only Reset clears.
//
// Ports:
//   Clk          system clock, all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   in_valid     instr_i carries a valid instruction this cycle
//   in_ready     issuer can accept instr_i this cycle (registered)
//   instr_i      instruction word: opcode [IW-1:IW-4], operand [IW-5:0]
//   out_valid    op_o / operand_o / flags are valid
//   out_ready    ALU side consumes the output this cycle
//   op_o         decoded ALU op
//   operand_o    operand field passed through
//   is_cmp_o     op is kSEQ, kSNE or kSLT
//   is_shift_o   op is kLSH or kRSH
//   err_o        sticky illegal-opcode flag
//   err_op_o     offending opcode value
//   issue_cnt_o  count of ops consumed downstream (wraps)
// ---------------------------------------------------------------------------
module alu_op_issue #(
  parameter int IW = 9,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    op_o,
  output logic [IW-5:0] operand_o,
  output logic          is_cmp_o,
  output logic          is_shift_o,
  output logic          err_o,
  output logic [3:0]    err_op_o,
  output logic [CW-1:0] issue_cnt_o
);

  localparam int OW = IW - 4;

  localparam logic [3:0] kADD = 4'h0;
  localparam logic [3:0] kSUB = 4'h1;
  localparam logic [3:0] kAND = 4'h2;
  localparam logic [3:0] kOR  = 4'h3;
  localparam logic [3:0] kXOR = 4'h4;
  localparam logic [3:0] kLSH = 4'h5;
  localparam logic [3:0] kRSH = 4'h6;
  localparam logic [3:0] kSEQ = 4'h7;
  localparam logic [3:0] kSNE = 4'h8;
  localparam logic [3:0] kSLT = 4'h9;

  typedef enum logic {
    sRun,
    sHalt
  } stateT;

  stateT state;
  stateT stateNext;

  logic          outValidQ, outValidD;
  logic [3:0]    outOpQ, outOpD;
  logic [OW-1:0] outOperandQ, outOperandD;
  logic          skidValidQ, skidValidD;
  logic [3:0]    skidOpQ, skidOpD;
  logic [OW-1:0] skidOperandQ, skidOperandD;
  logic          inReadyQ, inReadyD;
  logic          errQ, errD;
  logic [3:0]    errOpQ, errOpD;
  logic [CW-1:0] cntQ, cntD;

  logic [3:0]    inOp;
  logic [OW-1:0] inOperand;
  logic          opLegal;
  logic          accept;
  logic          acceptLegal;
  logic          acceptIllegal;
  logic          transfer;

  // Handshake qualifiers. Everything below runs from these, so in_ready stays
  // a pure register output. It never depends on out_ready.
  always_comb begin
    inOp          = instr_i[IW-1:IW-4];
    inOperand     = instr_i[IW-5:0];
    opLegal       = (inOp <= kSLT);
    accept        = in_valid && inReadyQ;
    acceptLegal   = accept && opLegal;
    acceptIllegal = accept && !opLegal;
    transfer      = outValidQ && out_ready;
  end

  // FSM state register. Reset is checked first, so it overrides any
  // handshake that happens on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= sRun;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic. An accepted illegal opcode ends RUN for good.
  // Only Reset leaves HALT.
  always_comb begin
    stateNext = state;
    case (state)
      sRun:    if (acceptIllegal) stateNext = sHalt;
      sHalt:   stateNext = sHalt;
      default: stateNext = sRun;
    endcase
  end

  // Datapath next-state logic for the output stage, the skid buffer, the
  // error capture and the transfer counter. A new op can only be accepted
  // while the skid buffer is empty. So on a transfer, a waiting skid entry
  // always wins the output stage, and an incoming op only lands in the skid
  // when the output stage is stalled. After a halt, ops already queued keep
  // draining, because nothing here depends on the FSM state.
  always_comb begin
    outValidD    = outValidQ;
    outOpD       = outOpQ;
    outOperandD  = outOperandQ;
    skidValidD   = skidValidQ;
    skidOpD      = skidOpQ;
    skidOperandD = skidOperandQ;
    errD         = errQ;
    errOpD       = errOpQ;
    cntD         = cntQ;

    if (transfer) begin
      cntD = cntQ + CW'(1);
      if (skidValidQ) begin
        outValidD   = 1'b1;
        outOpD      = skidOpQ;
        outOperandD = skidOperandQ;
        skidValidD  = 1'b0;
      end else if (acceptLegal) begin
        outValidD   = 1'b1;
        outOpD      = inOp;
        outOperandD = inOperand;
      end else begin
        outValidD   = 1'b0;
      end
    end else if (acceptLegal) begin
      if (!outValidQ) begin
        outValidD   = 1'b1;
        outOpD      = inOp;
        outOperandD = inOperand;
      end else begin
        skidValidD   = 1'b1;
        skidOpD      = inOp;
        skidOperandD = inOperand;
      end
    end

    if (acceptIllegal && !errQ) begin
      errD   = 1'b1;
      errOpD = inOp;
    end

    inReadyD = (stateNext == sRun) && !skidValidD;
  end

  // Datapath registers. Reset empties both stages and drops any buffered
  // op, so no stale op is issued after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      outValidQ    <= 1'b0;
      outOpQ       <= kADD;
      outOperandQ  <= '0;
      skidValidQ   <= 1'b0;
      skidOpQ      <= kADD;
      skidOperandQ <= '0;
      inReadyQ     <= 1'b1;
      errQ         <= 1'b0;
      errOpQ       <= 4'h0;
      cntQ         <= '0;
    end else begin
      outValidQ    <= outValidD;
      outOpQ       <= outOpD;
      outOperandQ  <= outOperandD;
      skidValidQ   <= skidValidD;
      skidOpQ      <= skidOpD;
      skidOperandQ <= skidOperandD;
      inReadyQ     <= inReadyD;
      errQ         <= errD;
      errOpQ       <= errOpD;
      cntQ         <= cntD;
    end
  end

  // Output logic. The class flags are decoded from the stored op, so they
  // stay stable along with it while the output stage is stalled.
  always_comb begin
    in_ready    = inReadyQ;
    out_valid   = outValidQ;
    op_o        = outOpQ;
    operand_o   = outOperandQ;
    is_cmp_o    = (outOpQ == kSEQ) || (outOpQ == kSNE) || (outOpQ == kSLT);
    is_shift_o  = (outOpQ == kLSH) || (outOpQ == kRSH);
    err_o       = errQ;
    err_op_o    = errOpQ;
    issue_cnt_o = cntQ;
  end

  // These opcodes are listed for completeness of the encoding table. The
  // decode above treats them only as members of the legal range.
  logic unusedOps;
  assign unusedOps = ^{kSUB, kAND, kOR, kXOR};

endmodule

// File: tb/tb_alu_op_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_op_issue
//
// Directed testbench for alu_op_issue. The counter width is set to 4 so that
// wrap-around can be reached. Inputs change 1 time unit after each rising
// edge, and outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_alu_op_issue;

  logic       Clk;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] instr_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] op_o;
  logic [4:0] operand_o;
  logic       is_cmp_o;
  logic       is_shift_o;
  logic       err_o;
  logic [3:0] err_op_o;
  logic [3:0] issue_cnt_o;

  int vectors;
  int miscompares;

  alu_op_issue #(
    .IW(9),
    .CW(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr_i(instr_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op_o(op_o),
    .operand_o(operand_o),
    .is_cmp_o(is_cmp_o),
    .is_shift_o(is_shift_o),
    .err_o(err_o),
    .err_op_o(err_op_o),
    .issue_cnt_o(issue_cnt_o)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Drive every DUT input at once, so each directed step is a single line.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [8:0] instr, input logic rdy);
    Reset     = rst;
    in_valid  = vld;
    instr_i   = instr;
    out_ready = rdy;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed stimulus sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_op", 16'(op_o), 16'h0);
    checkOutput("rst_operand", 16'(operand_o), 16'h0);
    checkOutput("rst_flags", 16'({is_cmp_o, is_shift_o}), 16'd0);
    checkOutput("rst_err", 16'({err_o, err_op_o}), 16'h0);
    checkOutput("rst_cnt", 16'(issue_cnt_o), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);

    // Single kSUB, operand 5
    applyStimulus(1'b0, 1'b1, 9'b0001_00101, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("sub_valid", 16'(out_valid), 16'd1);
    checkOutput("sub_op", 16'(op_o), 16'h1);
    checkOutput("sub_operand", 16'(operand_o), 16'h05);
    checkOutput("sub_cmp", 16'(is_cmp_o), 16'd0);
    checkOutput("sub_cnt_before", 16'(issue_cnt_o), 16'd0);
    tick();
    checkOutput("sub_drained", 16'(out_valid), 16'd0);
    checkOutput("sub_cnt", 16'(issue_cnt_o), 16'd1);

    // Back-to-back kADD, kLSH, kSLT at full throughput
    applyStimulus(1'b0, 1'b1, 9'b0000_00011, 1'b1);
    tick();
    checkOutput("b2b_op0", 16'(op_o), 16'h0);
    checkOutput("b2b_flags0", 16'({is_cmp_o, is_shift_o}), 16'b00);
    checkOutput("b2b_ready0", 16'(in_ready), 16'd1);
    applyStimulus(1'b0, 1'b1, 9'b0101_10000, 1'b1);
    tick();
    checkOutput("b2b_op5", 16'(op_o), 16'h5);
    checkOutput("b2b_operand5", 16'(operand_o), 16'h10);
    checkOutput("b2b_flags5", 16'({is_cmp_o, is_shift_o}), 16'b01);
    applyStimulus(1'b0, 1'b1, 9'b1001_01010, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("b2b_op9", 16'(op_o), 16'h9);
    checkOutput("b2b_flags9", 16'({is_cmp_o, is_shift_o}), 16'b10);
    checkOutput("b2b_valid9", 16'(out_valid), 16'd1);
    tick();
    checkOutput("b2b_drained", 16'(out_valid), 16'd0);
    checkOutput("b2b_cnt", 16'(issue_cnt_o), 16'd4);

    // Backpressure: kAND fills output, kOR fills skid
    applyStimulus(1'b0, 1'b1, 9'b0010_00001, 1'b0);
    tick();
    checkOutput("bp_op2", 16'(op_o), 16'h2);
    checkOutput("bp_ready_a", 16'(in_ready), 16'd1);
    applyStimulus(1'b0, 1'b1, 9'b0011_00010, 1'b0);
    tick();
    checkOutput("bp_hold_op", 16'(op_o), 16'h2);
    checkOutput("bp_hold_operand", 16'(operand_o), 16'h01);
    checkOutput("bp_ready_b", 16'(in_ready), 16'd0);
    // Offered while in_ready=0: must be ignored
    applyStimulus(1'b0, 1'b1, 9'b0100_11111, 1'b0);
    tick();
    checkOutput("bp_stall_op", 16'(op_o), 16'h2);
    checkOutput("bp_stall_valid", 16'(out_valid), 16'd1);
    checkOutput("bp_stall_cnt", 16'(issue_cnt_o), 16'd4);
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    tick();
    checkOutput("bp_drain_op", 16'(op_o), 16'h3);
    checkOutput("bp_drain_operand", 16'(operand_o), 16'h02);
    checkOutput("bp_drain_cnt", 16'(issue_cnt_o), 16'd5);
    checkOutput("bp_drain_ready", 16'(in_ready), 16'd1);
    tick();
    checkOutput("bp_empty", 16'(out_valid), 16'd0);
    checkOutput("bp_cnt", 16'(issue_cnt_o), 16'd6);

    // Illegal opcode 4'hC right after kXOR
    applyStimulus(1'b0, 1'b1, 9'b0100_00111, 1'b1);
    tick();
    checkOutput("ill_xor_op", 16'(op_o), 16'h4);
    applyStimulus(1'b0, 1'b1, 9'b1100_00000, 1'b1);
    tick();
    checkOutput("ill_err", 16'(err_o), 16'd1);
    checkOutput("ill_err_op", 16'(err_op_o), 16'hC);
    checkOutput("ill_ready", 16'(in_ready), 16'd0);
    checkOutput("ill_not_issued", 16'(out_valid), 16'd0);
    checkOutput("ill_cnt", 16'(issue_cnt_o), 16'd7);
    applyStimulus(1'b0, 1'b1, 9'b0001_00001, 1'b1);
    tick();
    tick();
    checkOutput("halt_ignore_valid", 16'(out_valid), 16'd0);
    checkOutput("halt_err_sticky", 16'({err_o, err_op_o}), 16'h1C);
    checkOutput("halt_ready", 16'(in_ready), 16'd0);
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("halt_rst_err", 16'({err_o, err_op_o}), 16'h00);
    checkOutput("halt_rst_ready", 16'(in_ready), 16'd1);
    checkOutput("halt_rst_cnt", 16'(issue_cnt_o), 16'd0);

    // Reset while output stage and skid buffer are both full
    applyStimulus(1'b0, 1'b1, 9'b0010_00100, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 9'b0011_01000, 1'b0);
    tick();
    checkOutput("full_ready", 16'(in_ready), 16'd0);
    checkOutput("full_valid", 16'(out_valid), 16'd1);
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("full_rst_valid", 16'(out_valid), 16'd0);
    checkOutput("full_rst_op", 16'(op_o), 16'h0);
    checkOutput("full_rst_cnt", 16'(issue_cnt_o), 16'd0);
    tick();
    checkOutput("full_no_stale", 16'(out_valid), 16'd0);
    checkOutput("full_no_stale_cnt", 16'(issue_cnt_o), 16'd0);

    // Counter wrap: 17 transfers with a 4-bit counter
    for (int i = 1; i <= 18; i++) begin
      if (i <= 17) applyStimulus(1'b0, 1'b1, 9'b0110_00000, 1'b1);
      else applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
      tick();
      checkOutput($sformatf("wrap_cnt_%0d", i), 16'(issue_cnt_o), 16'((i - 1) % 16));
    end
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("wrap_idle", 16'(out_valid), 16'd0);

    // Boundary: 4'hA is the first illegal opcode
    applyStimulus(1'b0, 1'b1, 9'b1010_00000, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 1'b1);
    checkOutput("illA_err", 16'({err_o, err_op_o}), 16'h1A);
    checkOutput("illA_valid", 16'(out_valid), 16'd0);
    checkOutput("illA_cnt", 16'(issue_cnt_o), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
